// File: rtl/alu_sequencer.sv
// Micro-sequencer that walks a small program RAM and drives the shared accumulator ALU
// one operation per step, aborting on the first ALU error code.
module alu_sequencer #(
  parameter int         AW      = 3,
  parameter int         ALU_LAT = 1,
  parameter logic [3:0] OP_CLR  = 4'b1100,
  parameter logic [3:0] OP_NOP  = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [36:0]   prog_wdata,
  input  logic [AW:0]   prog_len,
  input  logic [31:0]   arg_in,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_step,
  output logic [31:0]   alu_p,
  output logic [31:0]   alu_q,
  output logic [3:0]    alu_op,
  input  logic [31:0]   alu_out,
  input  logic [1:0]    alu_err
);

  // state | meaning
  // IDLE  | waiting for start; program RAM writable
  // CLR   | issue OP_CLR pseudo-step
  // ISSUE | ALU op and operands on the bus for one cycle
  // WAIT  | ALU_LAT cycles of ALU latency (down-counter)
  // CHECK | sample alu_out/alu_err, pick next step or finish
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, CHECK, DONE} seqState_t;

  localparam int          DEPTH  = 2 ** AW;
  localparam int          WW     = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW:0] MAXLEN = (AW + 1)'(DEPTH);

  seqState_t      state, nextState;
  logic [36:0]    progMem [DEPTH];
  logic [AW:0]    runLen;
  logic [AW:0]    curStep;
  logic [AW:0]    nextIdx;
  logic           inClr;
  logic           moreSteps;
  logic [31:0]    argReg;
  logic [WW-1:0]  waitCnt;
  logic [36:0]    entry;

  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) progMem[prog_addr] <= prog_wdata;
  end

  // nextIdx may reach 2^AW on the final step; it is then never used to read the RAM
  always_comb begin
    nextIdx   = inClr ? '0 : curStep + 1'b1;
    moreSteps = nextIdx < runLen;
    entry     = progMem[nextIdx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (start) nextState = CLR;
      CLR,
      ISSUE:     nextState = WAIT;
      WAIT:      if (waitCnt == '0) nextState = CHECK;
      CHECK: begin
        if (alu_err != 2'b00) nextState = DONE;
        else if (moreSteps)   nextState = ISSUE;
        else                  nextState = DONE;
      end
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      err_code <= '0;
      err_step <= '0;
      alu_p    <= '0;
      alu_q    <= '0;
      alu_op   <= OP_NOP;
      runLen   <= '0;
      curStep  <= '0;
      inClr    <= 1'b0;
      argReg   <= '0;
      waitCnt  <= '0;
    end else begin
      done   <= 1'b0;
      alu_op <= OP_NOP;
      alu_p  <= '0;
      alu_q  <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            runLen   <= (prog_len > MAXLEN) ? MAXLEN : prog_len;
            argReg   <= arg_in;
            err      <= 1'b0;
            err_code <= '0;
            err_step <= '0;
            busy     <= 1'b1;
            inClr    <= 1'b1;
            curStep  <= '0;
            alu_op   <= OP_CLR;
          end
        end
        CLR, ISSUE: waitCnt <= WW'(ALU_LAT - 1);
        WAIT:       if (waitCnt != '0) waitCnt <= waitCnt - 1'b1;
        CHECK: begin
          if (alu_err != 2'b00) begin
            err      <= 1'b1;
            err_code <= alu_err;
            err_step <= inClr ? '0 : curStep[AW-1:0];
            result   <= alu_out;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (moreSteps) begin
            inClr   <= 1'b0;
            curStep <= nextIdx;
            alu_op  <= entry[35:32];
            alu_p   <= entry[36] ? argReg : {16'h0000, entry[31:16]};
            alu_q   <= {16'h0000, entry[15:0]};
          end else begin
            result <= alu_out;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected run outcomes, a negedge
// monitor pops and compares whenever done pulses. Includes a behavioural 1-cycle ALU.
module tb_alu_sequencer;

  localparam int         AW     = 3;
  localparam logic [3:0] OP_CLR = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [36:0]   prog_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic [31:0]   arg_in = '0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [31:0]   result, alu_p, alu_q, alu_out;
  logic [1:0]    err_code, alu_err;
  logic [AW-1:0] err_step;
  logic [3:0]    alu_op;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.AW(AW), .ALU_LAT(1), .OP_CLR(OP_CLR), .OP_NOP(OP_NOP)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .arg_in(arg_in), .start(start),
    .busy(busy), .done(done), .result(result), .err(err), .err_code(err_code),
    .err_step(err_step), .alu_p(alu_p), .alu_q(alu_q), .alu_op(alu_op),
    .alu_out(alu_out), .alu_err(alu_err)
  );

  // ALU: 1111 acc=P^Q, 0010 acc*=P, 0011 acc/=P (P==0 -> err 01), 1100 clear, NOP holds
  logic [31:0] acc;
  logic [1:0]  aluErrR;
  assign alu_out = acc;
  assign alu_err = aluErrR;

  function automatic logic [31:0] ipow(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] r = 32'd1;
    for (int i = 0; i < int'(e) && i < 32; i++) r = r * b;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      acc <= '0; aluErrR <= 2'b00;
    end else begin
      case (alu_op)
        4'b1100: begin acc <= '0; aluErrR <= 2'b00; end
        4'b1111: begin acc <= ipow(alu_p, alu_q); aluErrR <= 2'b00; end
        4'b0010: begin acc <= acc * alu_p; aluErrR <= 2'b00; end
        4'b0011: begin
          if (alu_p == 0) aluErrR <= 2'b01;
          else begin acc <= acc / alu_p; aluErrR <= 2'b00; end
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [31:0]   res;
    logic          e;
    logic [1:0]    code;
    logic [AW-1:0] step;
    int            busyCyc;
    int            issues;
  } exp_t;

  exp_t sbQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: busy cycles and issue cycles (non-NOP op or nonzero Q) are counted per run
  int  busyCnt = 0;
  int  issueCnt = 0;
  logic prevDone = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0; issueCnt = 0; prevDone = 1'b0;
    end else begin
      if (busy) busyCnt++;
      if (alu_op != OP_NOP || alu_q != 0) issueCnt++;
      if (prevDone) chk("done_one_cycle", {31'b0, done}, 32'd0);
      if (done) begin
        doneCount++;
        if (sbQ.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = sbQ.pop_front();
          chk("result",     result,               x.res);
          chk("err",        {31'b0, err},         {31'b0, x.e});
          chk("err_code",   {30'b0, err_code},    {30'b0, x.code});
          chk("err_step",   {29'b0, err_step},    {29'b0, x.step});
          chk("busy_at_done", {31'b0, busy},      32'd0);
          chk("busy_cycles", busyCnt,             x.busyCyc);
          chk("issue_count", issueCnt,            x.issues);
        end
        busyCnt = 0; issueCnt = 0;
      end
      prevDone = done;
    end
  end

  function automatic logic [36:0] ent(input logic s, input logic [3:0] op,
                                      input logic [15:0] p, input logic [15:0] q);
    return {s, op, p, q};
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic e, input logic [1:0] c,
                              input logic [AW-1:0] st, input int b, input int iss);
    exp_t x;
    x.res = r; x.e = e; x.code = c; x.step = st; x.busyCyc = b; x.issues = iss;
    return x;
  endfunction

  task automatic writeEntry(input logic [AW-1:0] a, input logic [36:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic startRun(input logic [AW:0] len, input logic [31:0] arg);
    @(negedge clk);
    start = 1'b1; prog_len = len; arg_in = arg;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int base);
    int n = 0;
    while (doneCount == base && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (doneCount == base) begin
      chk("done_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
  endtask

  task automatic loadSphere();
    writeEntry(0, ent(1'b1, 4'b1111, 16'd0, 16'd3));
    writeEntry(1, ent(1'b0, 4'b0010, 16'd3141, 16'd0));
    writeEntry(2, ent(1'b0, 4'b0010, 16'd4, 16'd0));
    writeEntry(3, ent(1'b0, 4'b0011, 16'd3000, 16'd0));
  endtask

  // Busy cycles for N steps are 3N+3, so done is sampled on edge 3N+4 after acceptance
  initial begin
    int base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    chk("rst_err",    {31'b0, err},  32'd0);
    chk("rst_code",   {30'b0, err_code}, 32'd0);
    chk("rst_step",   {29'b0, err_step}, 32'd0);
    chk("rst_p",      alu_p,         32'd0);
    chk("rst_q",      alu_q,         32'd0);
    chk("rst_op",     {28'b0, alu_op}, {28'b0, OP_NOP});
    rst = 1'b0;

    loadSphere();
    sbQ.push_back(mk(32'd523, 1'b0, 2'b00, 3'd0, 15, 5));
    base = doneCount; startRun(4'd4, 32'd5); waitDone(base);

    sbQ.push_back(mk(32'd0, 1'b0, 2'b00, 3'd0, 3, 1));
    base = doneCount; startRun(4'd0, 32'd5); waitDone(base);

    writeEntry(2, ent(1'b0, 4'b0011, 16'd0, 16'd0));
    writeEntry(3, ent(1'b0, 4'b0010, 16'd4, 16'd0));
    sbQ.push_back(mk(32'd392625, 1'b1, 2'b01, 3'd2, 12, 4));
    base = doneCount; startRun(4'd4, 32'd5); waitDone(base);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Start re-pulse and RAM write during a run must both be ignored
    loadSphere();
    sbQ.push_back(mk(32'd523, 1'b0, 2'b00, 3'd0, 15, 5));
    base = doneCount; startRun(4'd4, 32'd5);
    repeat (3) @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 0;
    prog_wdata = ent(1'b0, 4'b1111, 16'd2, 16'd2);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    waitDone(base);
    repeat (4) @(negedge clk);
    sbQ.push_back(mk(32'd523, 1'b0, 2'b00, 3'd0, 15, 5));
    base = doneCount; startRun(4'd4, 32'd5); waitDone(base);

    // Reset during the WAIT of entry 1
    startRun(4'd4, 32'd5);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_op",   {28'b0, alu_op}, {28'b0, OP_NOP});
    chk("midrst_done", {31'b0, done}, 32'd0);
    repeat (20) @(negedge clk);
    sbQ.push_back(mk(32'd523, 1'b0, 2'b00, 3'd0, 15, 5));
    base = doneCount; startRun(4'd4, 32'd5); waitDone(base);

    // Write and start on the same edge: new entry 0 computes 7^2
    @(negedge clk);
    sbQ.push_back(mk(32'd49, 1'b0, 2'b00, 3'd0, 6, 2));
    base = doneCount;
    start = 1'b1; prog_len = 4'd1; arg_in = 32'd7;
    prog_we = 1'b1; prog_addr = 0; prog_wdata = ent(1'b1, 4'b1111, 16'd0, 16'd2);
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    waitDone(base);

    // Full program of NOPs tagged by Q; then an oversize prog_len that must saturate
    for (int i = 0; i < 8; i++) writeEntry(i[AW-1:0], ent(1'b0, OP_NOP, 16'd0, 16'(i + 1)));
    sbQ.push_back(mk(32'd0, 1'b0, 2'b00, 3'd0, 27, 9));
    base = doneCount; startRun(4'd8, 32'd0); waitDone(base);
    sbQ.push_back(mk(32'd0, 1'b0, 2'b00, 3'd0, 27, 9));
    base = doneCount; startRun(4'd15, 32'd0); waitDone(base);

    repeat (5) @(negedge clk);
    chk("sb_drained", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Micro-sequencer that drives the shared accumulator ALU through a stored list of operations, so a multi-step calculation (e.g. sphere volume (1000*4*pi*r^3)/3000) runs from a single start pulse instead of hand-timed stimulus.
- Holds a small program RAM written by the host/middleware, substitutes a run-time argument where an entry is flagged, issues one ALU op per step and checks the ALU error code after every step.
- Reports the final result, a done pulse, and the error code plus step index on abort.

Parameters:
- AW, 3, program address width; the program RAM holds 2^AW entries.
- ALU_LAT, 1, cycles from the end of an ALU issue cycle to the cycle in which alu_out/alu_err are sampled.
- OP_CLR, 4'b1100, ALU opcode that clears the accumulator.
- OP_NOP, 4'b0000, opcode driven whenever no step is being issued.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_wdata  in  37  program entry: [36] sel_arg, [35:32] opcode, [31:16] P immediate, [15:0] Q immediate.
- prog_len  in  AW+1  number of entries to run (0..2^AW); sampled with start.
- arg_in  in  32  run-time argument; sampled with start.
- start  in  1  run request (level; acted on only in IDLE).
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse at the end of a run (normal or aborted).
- result  out  32  alu_out captured at the last sample; held until the next start.
- err  out  1  run aborted on an ALU error; sticky until the next start.
- err_code  out  2  alu_err value that caused the abort.
- err_step  out  AW  index of the failing entry.
- alu_p  out  32  ALU inputP.
- alu_q  out  32  ALU inputQ.
- alu_op  out  4  ALU opCode.
- alu_out  in  32  ALU outALU.
- alu_err  in  2  ALU errorCode; 2'b00 means no error.

Behaviour:
- Reset values: busy=0, done=0, result=0, err=0, err_code=0, err_step=0, alu_p=0, alu_q=0, alu_op=OP_NOP. State returns to IDLE. Program RAM contents are not reset.
- Program RAM writes: a write with prog_we=1 in IDLE stores prog_wdata at prog_addr on the clock edge. Writes while busy are dropped.
- States:
  - IDLE.
  - CLR: issue OP_CLR with P=0, Q=0.
  - ISSUE: one cycle; drive the step's op and operands.
  - WAIT: ALU_LAT cycles.
  - CHECK: sample alu_out/alu_err.
  - DONE: one cycle; done=1.
- IDLE -> CLR when start=1. On that edge latch prog_len and arg_in, clear err/err_code/err_step, set busy=1.
- CLR behaves as ISSUE for a pseudo-step; it is followed by WAIT and CHECK.
- ISSUE for entry k:
  - alu_op = opcode.
  - alu_p = sel_arg ? arg_in : zero-extended P immediate.
  - alu_q = zero-extended Q immediate.
  - Outputs are registered and held for exactly one cycle; alu_op returns to OP_NOP in every non-ISSUE/CLR cycle.
- CHECK:
  - If alu_err != 0: latch err=1, err_code=alu_err, err_step=k (0 for CLR), result=alu_out, go to DONE.
  - Else if more entries remain: go to ISSUE with k+1.
  - Else: result=alu_out, go to DONE.
- DONE: done=1, busy=0, go to IDLE.
- Step period is 1+ALU_LAT+1 cycles. For prog_len=N, done pulses (N+1)*(ALU_LAT+2)+1 cycles after the edge that accepts start; with ALU_LAT=1 that is 3N+4.
- prog_len=0: run CLR only; result=0 (the post-clear accumulator).
- prog_len > 2^AW is saturated to 2^AW.
- The step counter must not wrap: a run of 2^AW entries ends after entry 2^AW-1.
- start while busy is ignored and is not queued. start held high re-triggers in the IDLE cycle after DONE.
- rst mid-run: immediate return to IDLE on that edge; outputs take their reset values; no done pulse.
- Simultaneous prog_we and start in IDLE: the write completes and the run starts on the same edge. RAM reads happen in ISSUE, so the new entry is visible to the run.

Test Plan:
- Sphere, ALU_LAT=1, arg_in=5, prog_len=4, entries {1,1111,x,3}, {0,0010,3141,0}, {0,0010,4,0}, {0,0011,3000,0} -> result=523, err=0, done 16 cycles after start, busy high for exactly 15 cycles.
- prog_len=0 with start -> OP_CLR issued once, result=0, done after 4 cycles.
- Entry 2 = {0,0011,0,0} (divide by zero); ALU model returns alu_err=2'b01 -> abort, err=1, err_code=01, err_step=2, done pulses, entry 3 never issued.
- start re-pulsed and prog_we asserted during a run -> no second run, RAM entry unchanged, original result still produced.
- rst asserted during the WAIT of entry 1 -> next cycle busy=0, alu_op=OP_NOP, no done; a fresh start then runs correctly from CLR.
- Full program (prog_len=2^AW) of OP_NOP steps -> exactly 2^AW issues, no index wrap, done at (2^AW+1)*3+1 cycles.
